// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner: per-frame input snapshot, hex decode,
// anti-ghost guard, leading-zero blanking, decimal points and per-digit blink.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned GUARD          = 4,
  parameter int unsigned BLINK_FRAMES   = 125,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SEL_3,
  input  logic [3:0] SEL_2,
  input  logic [3:0] SEL_1,
  input  logic [3:0] SEL_0,
  input  logic [3:0] DP_MASK,
  input  logic [3:0] BLINK_MASK,
  input  logic       LZ_BLANK,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [FrmW-1:0] FrmMax = FrmW'(BLINK_FRAMES - 1);
  localparam logic [6:0] SegOff = {7{SEG_ACTIVE_LOW}};
  localparam logic       DpOff  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AnOff  = {4{AN_ACTIVE_LOW}};

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [FrmW-1:0] frame_q, frame_d;
  logic            phase_q, phase_d;

  logic [3:0][3:0] sel_q;
  logic [3:0]      dp_mask_q;
  logic [3:0]      blink_mask_q;
  logic            lz_q;

  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] an_q, an_d;

  logic       snap;
  logic [3:0] lz_run;
  logic [3:0] digit;
  logic       blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slot, digit, frame and blink-phase sequencing.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        if (frame_q == FrmMax) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
    end
  end

  assign snap = (cnt_q == '0) && (idx_q == 2'd0);

  // lz_run[k]: shadow digits k..3 are all zero; digit 0 is never suppressed.
  always_comb begin
    lz_run    = 4'b0000;
    lz_run[3] = (sel_q[3] == 4'h0);
    lz_run[2] = lz_run[3] && (sel_q[2] == 4'h0);
    lz_run[1] = lz_run[2] && (sel_q[1] == 4'h0);
  end

  always_comb begin
    digit = sel_q[idx_q];
    blank = (32'(cnt_q) < GUARD)
         || (phase_q && blink_mask_q[idx_q])
         || (lz_q && lz_run[idx_q]);
    seg_d = SegOff;
    dp_d  = DpOff;
    an_d  = AnOff;
    if (!blank) begin
      seg_d = hex7(digit) ^ SegOff;
      dp_d  = dp_mask_q[idx_q] ^ DpOff;
      an_d  = (4'b0001 << idx_q) ^ AnOff;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      frame_q      <= '0;
      phase_q      <= 1'b0;
      sel_q        <= '0;
      dp_mask_q    <= 4'b0000;
      blink_mask_q <= 4'b0000;
      lz_q         <= 1'b0;
      seg_q        <= SegOff;
      dp_q         <= DpOff;
      an_q         <= AnOff;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      if (snap) begin
        sel_q        <= {SEL_3, SEL_2, SEL_1, SEL_0};
        dp_mask_q    <= DP_MASK;
        blink_mask_q <= BLINK_MASK;
        lz_q         <= LZ_BLANK;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign SEG = seg_q;
  assign DP  = dp_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2, active-low pins.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sel3, sel2, sel1, sel0;
  logic [3:0] dp_mask, blink_mask;
  logic       lz;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;

  logic [6:0] exp_seg [4];
  bit         lit     [4];
  bit         dp_on   [4];

  // Hand-inverted decode table, index = digit value.
  logic [6:0] hex_inv [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(
    .SCAN_DIV      (8),
    .GUARD         (2),
    .BLINK_FRAMES  (2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .SEL_3     (sel3),
    .SEL_2     (sel2),
    .SEL_1     (sel1),
    .SEL_0     (sel0),
    .DP_MASK   (dp_mask),
    .BLINK_MASK(blink_mask),
    .LZ_BLANK  (lz),
    .SEG       (seg),
    .DP        (dp),
    .AN        (an)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) check_eq("an_onehot", 32'($countones(~an) <= 1), 32'd1);

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_an%0d", i), an, 4'hF);
      check_eq($sformatf("rst_seg%0d", i), seg, 7'h7F);
      check_eq($sformatf("rst_dp%0d", i), dp, 1'b1);
    end
    rst = 1'b0;
    pos = 0;
  endtask

  // Each sampled cycle reflects slot position pos (cnt = pos%8, idx = (pos/8)%4).
  task automatic check_cycles(input int n);
    int         c, d;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c = pos % 8;
      d = (pos / 8) % 4;
      if (c < 2 || !lit[d]) begin
        ean  = 4'hF;
        eseg = 7'h7F;
        edp  = 1'b1;
      end else begin
        ean  = ~(4'b0001 << d);
        eseg = exp_seg[d];
        edp  = ~dp_on[d];
      end
      check_eq($sformatf("an@%0d", pos), an, ean);
      check_eq($sformatf("seg@%0d", pos), seg, eseg);
      check_eq($sformatf("dp@%0d", pos), dp, edp);
      pos++;
    end
  endtask

  initial begin
    sel0 = 4'd1; sel1 = 4'd2; sel2 = 4'd3; sel3 = 4'd4;
    dp_mask = 4'b0000; blink_mask = 4'b0000; lz = 1'b0;
    lit   = '{1, 1, 1, 1};
    dp_on = '{0, 0, 0, 0};

    // Reset and scan order.
    do_reset();
    exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
    check_cycles(32);

    // Change on the snapshot cycle is captured; mid-frame change waits a frame.
    sel0 = 4'd4;
    exp_seg[0] = 7'h19;
    check_cycles(20);
    sel0 = 4'd9;
    sel3 = 4'd8;
    check_cycles(12);
    exp_seg[0] = 7'h10;
    exp_seg[3] = 7'h00;
    check_cycles(32);

    // Reset inside digit 2's slot, then a fresh snapshot from digit 0.
    check_cycles(20);
    sel0 = 4'd5; sel1 = 4'd6; sel2 = 4'd7; sel3 = 4'd8;
    do_reset();
    exp_seg = '{7'h12, 7'h02, 7'h78, 7'h00};
    check_cycles(32);

    // Leading-zero blanking.
    lz = 1'b1;
    sel3 = 4'd0; sel2 = 4'd0; sel1 = 4'd0; sel0 = 4'd5;
    lit = '{1, 0, 0, 0};
    exp_seg[0] = 7'h12;
    check_cycles(32);
    sel0 = 4'd0;
    exp_seg[0] = 7'h40;
    check_cycles(32);
    sel2 = 4'd7;
    lit = '{1, 1, 1, 0};
    exp_seg = '{7'h40, 7'h40, 7'h78, 7'h7F};
    check_cycles(32);

    // Hex sweep on digit 0 with zeros elsewhere shown (blanking off).
    lz = 1'b0;
    sel2 = 4'd0;
    lit = '{1, 1, 1, 1};
    for (int v = 0; v < 16; v++) begin
      sel0 = 4'(v);
      exp_seg = '{hex_inv[v], 7'h40, 7'h40, 7'h40};
      check_cycles(32);
    end

    // Blink on digit 0 and decimal point on digit 2.
    sel0 = 4'd1; sel1 = 4'd2; sel2 = 4'd3; sel3 = 4'd4;
    blink_mask = 4'b0001;
    dp_mask    = 4'b0100;
    do_reset();
    exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
    dp_on   = '{0, 0, 1, 0};
    for (int f = 0; f < 5; f++) begin
      lit[0] = ((f / 2) % 2 == 0);
      check_cycles(32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
